// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Conditions raw push-button / switch inputs for downstream
//               logic. Each channel is normalised to active-high, passed
//               through a two-flop synchroniser, debounced by a stability
//               counter and given one-cycle press (rise) / release (fall)
//               pulses that line up with the new debounced level.
//
// Ports       : clock      - system clock, all logic on the rising edge
//               reset_n    - asynchronous, active-low reset
//               raw_in     - [WIDTH] asynchronous raw button/switch inputs
//               level_out  - [WIDTH] debounced active-high level per channel
//               rise_pulse - [WIDTH] one-cycle pulse on a 0->1 level change
//               fall_pulse - [WIDTH] one-cycle pulse on a 1->0 level change
//
// Parameters  : WIDTH         - number of independent channels
//               STABLE_CYCLES - cycles a new value must persist (>= 2)
//               ACTIVE_LOW    - 1: raw inputs are active-low and inverted
//
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(STABLE_CYCLES);

    // Terminal count: the edge that sees the counter here with the input
    // still differing is the STABLE_CYCLES-th consecutive differing edge.
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // XOR mask that turns active-low inputs into active-high levels.
    localparam logic [WIDTH-1:0] c_pol_mask = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // Per-channel FSM encoding.
    localparam logic [0:0] c_st_stable  = 1'b0;
    localparam logic [0:0] c_st_confirm = 1'b1;

    // ------------------------------------------------------------------------
    // Normalisation and synchroniser (shared by all channels)
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_norm;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    assign w_norm = raw_in ^ c_pol_mask;

    // Both stages reset to the inactive logical value so that a key held
    // through reset is seen as a fresh press once reset is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= {WIDTH{1'b0}};
            r_sync2 <= {WIDTH{1'b0}};
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debounce FSM
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan

            logic [0:0]       r_state;
            logic [0:0]       w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             r_level;
            logic             r_rise;
            logic             r_fall;
            logic             w_level_nxt;
            logic             w_rise_nxt;
            logic             w_fall_nxt;
            logic             w_differs;
            logic             w_expired;

            // Synchronised input disagrees with the accepted level.
            assign w_differs = (r_sync2[i] != r_level);
            assign w_expired = (r_cnt == c_cnt_max);

            // ---- State register (also holds counter and registered outputs)
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= c_st_stable;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_level <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_level <= w_level_nxt;
                    r_rise  <= w_rise_nxt;
                    r_fall  <= w_fall_nxt;
                end
            end

            // ---- Next-state logic
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    c_st_stable: begin
                        if (w_differs) begin
                            // The first differing edge already counts as one.
                            w_state_nxt = c_st_confirm;
                            w_cnt_nxt   = c_cnt_one;
                        end else begin
                            w_cnt_nxt   = {CNT_W{1'b0}};
                        end
                    end
                    c_st_confirm: begin
                        if (!w_differs) begin
                            // Bounced back before the window closed.
                            w_state_nxt = c_st_stable;
                            w_cnt_nxt   = {CNT_W{1'b0}};
                        end else if (w_expired) begin
                            // New value accepted this edge.
                            w_state_nxt = c_st_stable;
                            w_cnt_nxt   = {CNT_W{1'b0}};
                        end else begin
                            w_cnt_nxt   = r_cnt + c_cnt_one;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_stable;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end
                endcase
            end

            // ---- Output logic (values registered above, so the pulse lands
            //      in the same cycle the new level first appears)
            always_comb begin
                w_level_nxt = r_level;
                w_rise_nxt  = 1'b0;
                w_fall_nxt  = 1'b0;
                if ((r_state == c_st_confirm) && w_differs && w_expired) begin
                    w_level_nxt = ~r_level;
                    w_rise_nxt  = ~r_level;
                    w_fall_nxt  = r_level;
                end
            end

            assign level_out[i]  = r_level;
            assign rise_pulse[i] = r_rise;
            assign fall_pulse[i] = r_fall;

        end
    endgenerate

endmodule
`default_nettype wire
